// File: rtl/fp_addsub_pipe.sv
// Pipelined FP add/sub with tag pass-through, accumulator mode and sticky status; latency num_stages cycles.
// Backpressure: all stages stall together while out_valid && !out_ready; in_ready also drops while an acc op is in flight.
module fp_addsub_pipe #(
    parameter int sig_width       = 23,
    parameter int exp_width       = 8,
    parameter int ieee_compliance = 0,
    parameter int num_stages      = 2,
    parameter int tag_width       = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [sig_width+exp_width:0]   in_a,
    input  logic [sig_width+exp_width:0]   in_b,
    input  logic [2:0]                     in_rnd,
    input  logic                           in_op,
    input  logic                           in_acc,
    input  logic [tag_width-1:0]           in_tag,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [sig_width+exp_width:0]   out_z,
    output logic [7:0]                     out_status,
    output logic [tag_width-1:0]           out_tag,
    input  logic                           acc_clr,
    output logic [sig_width+exp_width:0]   acc_q,
    output logic [7:0]                     sticky_status,
    input  logic                           status_clr
);
    localparam int W  = sig_width + exp_width + 1;
    localparam int M  = sig_width + 1;
    localparam int X  = M + 3;
    localparam int EW = exp_width + 2;
    localparam int L  = num_stages - 1;
    localparam logic [exp_width-1:0] EMAX = '1;
    localparam logic [exp_width-1:0] EONE = {{(exp_width-1){1'b0}}, 1'b1};

    logic [W-1:0] opb, core_z;
    logic [7:0]   core_st;

    assign opb = in_acc ? acc_q : in_b;

    always_comb begin
        logic sa, sb, swap, s_big, eff_sub, a_inf, b_inf, a_nan, b_nan, g, rs, inc, uflow, oflow;
        logic [exp_width-1:0] ea, eb, e_big, e_sml, d;
        logic [M-1:0] ma, mb, m_big, m_sml;
        logic [X-1:0] x_big, x_sml, x_norm;
        logic [X:0]   sum;
        logic [EW-1:0] e_n;
        logic [M:0]   mant;
        int lz, sh;
        core_z  = '0;
        core_st = '0;
        sa = in_a[W-1];
        sb = opb[W-1] ^ in_op;
        eff_sub = sa ^ sb;
        ea = in_a[W-2:sig_width];
        eb = opb[W-2:sig_width];
        a_inf = (ea == EMAX);
        b_inf = (eb == EMAX);
        a_nan = (ieee_compliance != 0) && a_inf && (in_a[sig_width-1:0] != '0);
        b_nan = (ieee_compliance != 0) && b_inf && (opb[sig_width-1:0] != '0);
        ma = {(ea != '0), in_a[sig_width-1:0]};
        mb = {(eb != '0), opb[sig_width-1:0]};
        // Subnormals sit at exponent 1 without hidden bit; flushed to zero when not IEEE-compliant
        if (ieee_compliance == 0 && ea == '0) ma = '0;
        if (ieee_compliance == 0 && eb == '0) mb = '0;
        if (ea == '0) ea = EONE;
        if (eb == '0) eb = EONE;
        swap  = {eb, mb} > {ea, ma};
        e_big = swap ? eb : ea;
        e_sml = swap ? ea : eb;
        m_big = swap ? mb : ma;
        m_sml = swap ? ma : mb;
        s_big = swap ? sb : sa;
        d = e_big - e_sml;
        x_big = {m_big, 3'b000};
        x_sml = {m_sml, 3'b000};
        for (int i = 0; i < X; i++) begin
            if (i < int'(d)) x_sml = {1'b0, x_sml[X-1:2], x_sml[1] | x_sml[0]};
        end
        sum = eff_sub ? ({1'b0, x_big} - {1'b0, x_sml}) : ({1'b0, x_big} + {1'b0, x_sml});
        lz = X;
        for (int i = 0; i < X; i++) begin
            if (sum[i]) lz = X - 1 - i;
        end
        sh = lz;
        uflow = 1'b0;
        if (sum[X]) begin
            x_norm = {sum[X:2], sum[1] | sum[0]};
            e_n    = {2'b00, e_big} + {{(EW-1){1'b0}}, 1'b1};
        end else begin
            if (lz >= int'(e_big)) begin
                if (ieee_compliance != 0) sh = int'(e_big) - 1;
                else uflow = (sum != '0);
            end
            x_norm = sum[X-1:0] << sh;
            e_n    = {2'b00, e_big} - EW'(sh);
        end
        g  = x_norm[2];
        rs = x_norm[1] | x_norm[0];
        case (in_rnd)
            3'd0:    inc = g & (rs | x_norm[3]);
            3'd2:    inc = ~s_big & (g | rs);
            3'd3:    inc = s_big & (g | rs);
            3'd4:    inc = g;
            3'd5:    inc = g | rs;
            default: inc = 1'b0;
        endcase
        mant = {1'b0, x_norm[X-1:3]} + {{M{1'b0}}, inc};
        if (mant[M]) begin
            mant = mant >> 1;
            e_n  = e_n + {{(EW-1){1'b0}}, 1'b1};
        end
        oflow = (e_n >= {2'b00, EMAX});
        if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
            core_z = {1'b0, EMAX, {sig_width{1'b0}}};
            if (ieee_compliance != 0) core_z[sig_width-1] = 1'b1;
            core_st[2] = 1'b1;
        end else if (a_inf || b_inf) begin
            core_z = {(a_inf ? sa : sb), EMAX, {sig_width{1'b0}}};
            core_st[1] = 1'b1;
        end else if (sum == '0) begin
            // Exact cancellation gives +0 except when rounding toward -inf
            core_z = {(eff_sub ? (in_rnd == 3'd3) : sa), {(W-1){1'b0}}};
            core_st[0] = 1'b1;
        end else if (uflow) begin
            core_z = {s_big, {(W-1){1'b0}}};
            core_st[0] = 1'b1;
            core_st[3] = 1'b1;
            core_st[5] = 1'b1;
        end else if (oflow) begin
            core_st[4] = 1'b1;
            core_st[5] = 1'b1;
            if (in_rnd == 3'd1 || (in_rnd == 3'd2 && s_big) || (in_rnd == 3'd3 && !s_big)) begin
                core_z = {s_big, EMAX - EONE, {sig_width{1'b1}}};
            end else begin
                core_z = {s_big, EMAX, {sig_width{1'b0}}};
                core_st[1] = 1'b1;
            end
        end else begin
            core_z = {s_big, (mant[M-1] ? e_n[exp_width-1:0] : {exp_width{1'b0}}), mant[M-2:0]};
            core_st[5] = g | rs;
            core_st[3] = ~mant[M-1] & (g | rs);
        end
    end

    logic [num_stages-1:0] vld_q, accf_q;
    logic [W-1:0]          z_q   [num_stages];
    logic [7:0]            st_q  [num_stages];
    logic [tag_width-1:0]  tag_q [num_stages];
    logic                  advance, acc_busy, accept, out_hs;
    logic [W-1:0]          acc_d;
    logic [7:0]            sticky_q, sticky_d;

    assign out_valid = vld_q[L];
    assign out_z     = z_q[L];
    assign out_status = st_q[L];
    assign out_tag   = tag_q[L];
    assign advance   = !out_valid || out_ready;
    assign acc_busy  = |(vld_q & accf_q);
    assign in_ready  = advance && !acc_busy;
    assign accept    = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign sticky_status = sticky_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            accf_q <= '0;
            for (int i = 0; i < num_stages; i++) begin
                z_q[i]   <= '0;
                st_q[i]  <= '0;
                tag_q[i] <= '0;
            end
        end else if (advance) begin
            vld_q[0]  <= accept;
            accf_q[0] <= accept && in_acc;
            z_q[0]    <= core_z;
            st_q[0]   <= core_st;
            tag_q[0]  <= in_tag;
            for (int i = 1; i < num_stages; i++) begin
                vld_q[i]  <= vld_q[i-1];
                accf_q[i] <= accf_q[i-1];
                z_q[i]    <= z_q[i-1];
                st_q[i]   <= st_q[i-1];
                tag_q[i]  <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (out_hs && accf_q[L]) acc_d = out_z;
        if (acc_clr) acc_d = '0;
        sticky_d = sticky_q;
        if (status_clr) sticky_d = '0;
        if (out_hs) sticky_d = sticky_d | out_status;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            sticky_q <= '0;
        end else begin
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
        end
    end
endmodule
